// File: rtl/input_vc_buffer_pkg.sv
// -----------------------------------------------------------------------------
// input_vc_buffer_pkg
// Shared definitions for the router input-port VC buffer.
//   FLIT_SIZE       flit width in bits (overridable on the command line)
//   IN_OUTPORT_CNT  number of router ports
//   VC_ID_WIDTH     default width of the VC id field
//   CLOG2(x)        ceiling log2 helper
//   CREDIT_IDX(v,p) position of the credit for VC v of port p inside an
//                   upstream router's credit vector: v*IN_OUTPORT_CNT+p
// Optional feature macro used by this block: INPUT_BUF_OCC_EN.
// -----------------------------------------------------------------------------
`ifndef FLIT_SIZE
`define FLIT_SIZE 8
`endif
`ifndef IN_OUTPORT_CNT
`define IN_OUTPORT_CNT 5
`endif
`ifndef VC_ID_WIDTH
`define VC_ID_WIDTH 2
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef CREDIT_IDX
`define CREDIT_IDX(v, p) ((v) * `IN_OUTPORT_CNT + (p))
`endif

package input_vc_buffer_pkg;

    localparam int FLIT_W_DEF    = `FLIT_SIZE;
    localparam int VC_NUM_DEF    = 4;
    localparam int VC_ID_W_DEF   = `VC_ID_WIDTH;
    localparam int BUF_DEPTH_DEF = 4;

    // Per-VC FIFO control state
    typedef enum logic [0:0] {
        FIFO_EMPTY    = 1'b0,
        FIFO_NONEMPTY = 1'b1
    } fifo_state_e;

endpackage

// File: rtl/input_vc_buffer_if.sv
// -----------------------------------------------------------------------------
// input_vc_buffer_if
// Link/allocator bundle of one router input port.
//   flit_in/flit_valid/flit_vc  incoming flit from the upstream link
//   pop                         allocator grant, one bit per VC (bit 0 = VC 0)
//   head_flits                  head flit of each VC, VC 0 in the low FLIT_W bits
//   is_new_flit                 VC non-empty (head_flits slice valid)
//   credit_out                  one-cycle credit pulse per VC to upstream
//   overflow_err                sticky: flit arrived for a full or invalid VC
//   buf_occupancy/buf_full      only with INPUT_BUF_OCC_EN defined
// master = upstream link + allocator side, slave = the buffer.
// -----------------------------------------------------------------------------
interface input_vc_buffer_if
    import input_vc_buffer_pkg::*;
#(
    parameter int VC_NUM    = VC_NUM_DEF,
    parameter int VC_ID_W   = VC_ID_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int FLIT_W    = FLIT_W_DEF
) ();

    localparam int CNT_W = `CLOG2(BUF_DEPTH) + 1;

    logic [FLIT_W-1:0]        flit_in;
    logic                     flit_valid;
    logic [VC_ID_W-1:0]       flit_vc;
    logic [VC_NUM-1:0]        pop;
    logic [FLIT_W*VC_NUM-1:0] head_flits;
    logic [VC_NUM-1:0]        is_new_flit;
    logic [VC_NUM-1:0]        credit_out;
    logic                     overflow_err;
`ifdef INPUT_BUF_OCC_EN
    logic [CNT_W*VC_NUM-1:0]  buf_occupancy;
    logic [VC_NUM-1:0]        buf_full;

    modport master (
        output flit_in, flit_valid, flit_vc, pop,
        input  head_flits, is_new_flit, credit_out, overflow_err, buf_occupancy, buf_full
    );
    modport slave (
        input  flit_in, flit_valid, flit_vc, pop,
        output head_flits, is_new_flit, credit_out, overflow_err, buf_occupancy, buf_full
    );
`else
    modport master (
        output flit_in, flit_valid, flit_vc, pop,
        input  head_flits, is_new_flit, credit_out, overflow_err
    );
    modport slave (
        input  flit_in, flit_valid, flit_vc, pop,
        output head_flits, is_new_flit, credit_out, overflow_err
    );
`endif

endinterface

// File: rtl/input_vc_buffer_vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// Single-VC flit FIFO with credit return.
//   clk, reset  rising-edge clock, synchronous active-high reset
//   push_i      write data_i (ignored when full unless popped the same cycle)
//   pop_i       remove head flit (ignored when empty)
//   data_i      flit to store
//   head_o      head flit, forced to zero when empty
//   count_o     registered occupancy 0..BUF_DEPTH
//   empty_o     FIFO holds no flit
//   full_o      FIFO holds BUF_DEPTH flits
//   credit_o    registered one-cycle pulse after each effective pop
// -----------------------------------------------------------------------------
module vc_fifo
    import input_vc_buffer_pkg::*;
#(
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int FLIT_W    = FLIT_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        push_i,
    input  logic                        pop_i,
    input  logic [FLIT_W-1:0]           data_i,
    output logic [FLIT_W-1:0]           head_o,
    output logic [`CLOG2(BUF_DEPTH):0]  count_o,
    output logic                        empty_o,
    output logic                        full_o,
    output logic                        credit_o
);

    localparam int PTR_W = `CLOG2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    fifo_state_e       state_q, state_d;
    logic [FLIT_W-1:0] mem_q [BUF_DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              credit_q;
    logic              empty_s, full_s, do_push_s, do_pop_s;

    // A full FIFO still accepts a write when the same edge pops a slot.
    assign do_pop_s  = pop_i && !empty_s;
    assign do_push_s = push_i && (!full_s || pop_i);

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= FIFO_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            FIFO_EMPTY: begin
                if (do_push_s) state_d = FIFO_NONEMPTY;
                else           state_d = FIFO_EMPTY;
            end
            FIFO_NONEMPTY: begin
                if ((count_q == CNT_W'(1)) && do_pop_s && !do_push_s) state_d = FIFO_EMPTY;
                else                                                   state_d = FIFO_NONEMPTY;
            end
            default: state_d = FIFO_EMPTY;
        endcase
    end

    // FSM output decode
    always_comb begin
        empty_s = 1'b1;
        full_s  = 1'b0;
        case (state_q)
            FIFO_EMPTY: begin
                empty_s = 1'b1;
                full_s  = 1'b0;
            end
            FIFO_NONEMPTY: begin
                empty_s = 1'b0;
                full_s  = (count_q == CNT_W'(BUF_DEPTH));
            end
            default: begin
                empty_s = 1'b1;
                full_s  = 1'b0;
            end
        endcase
    end

    // Pointer and occupancy next-state; pointers wrap modulo BUF_DEPTH
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push_s) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        else           wr_ptr_d = wr_ptr_q;
        if (do_pop_s)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        else           rd_ptr_d = rd_ptr_q;
        case ({do_push_s, do_pop_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer, occupancy and credit registers
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            credit_q <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            credit_q <= do_pop_s;
        end
    end

    // Flit storage; stale contents are hidden by the pointers after reset
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // Head flit read-out, zero while empty
    always_comb begin
        if (empty_s) head_o = {FLIT_W{1'b0}};
        else         head_o = mem_q[rd_ptr_q];
    end

    assign count_o  = count_q;
    assign empty_o  = empty_s;
    assign full_o   = full_s;
    assign credit_o = credit_q;

endmodule

// File: rtl/input_vc_buffer.sv
// -----------------------------------------------------------------------------
// input_vc_buffer
// Receiver side of one router input port on a credit-based link: per-VC
// FIFOs feeding the switch allocator, with one credit returned per pop.
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    input_vc_buffer_if.slave (flit link, allocator grant, head flits,
//          valid flags, credit pulses, sticky overflow error)
// Optional feature: define INPUT_BUF_OCC_EN to drive bus.buf_occupancy and
// bus.buf_full.
// -----------------------------------------------------------------------------
module input_vc_buffer
    import input_vc_buffer_pkg::*;
#(
    parameter int VC_NUM    = VC_NUM_DEF,
    parameter int VC_ID_W   = VC_ID_W_DEF,
    parameter int BUF_DEPTH = BUF_DEPTH_DEF,
    parameter int FLIT_W    = FLIT_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input_vc_buffer_if.slave   bus
);

    localparam int CNT_W = `CLOG2(BUF_DEPTH) + 1;

    logic [VC_NUM-1:0]        push_s, drop_s, empty_s, full_s, credit_s;
    logic [FLIT_W*VC_NUM-1:0] head_flat_s;
    logic [CNT_W*VC_NUM-1:0]  count_flat_s;
    logic                     bad_vc_s;
    logic                     overflow_q, overflow_d;

    // Ids that name no existing VC are dropped and flagged.
    assign bad_vc_s = bus.flit_valid && (32'(bus.flit_vc) >= 32'(VC_NUM));

    // A write is lost when its VC is full and not popped the same cycle.
    assign drop_s = push_s & full_s & ~bus.pop;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_vc
        assign push_s[v] = bus.flit_valid && (bus.flit_vc == VC_ID_W'(v));

        vc_fifo #(
            .BUF_DEPTH (BUF_DEPTH),
            .FLIT_W    (FLIT_W)
        ) u_vc_fifo (
            .clk      (clk),
            .reset    (reset),
            .push_i   (push_s[v]),
            .pop_i    (bus.pop[v]),
            .data_i   (bus.flit_in),
            .head_o   (head_flat_s[v*FLIT_W +: FLIT_W]),
            .count_o  (count_flat_s[v*CNT_W +: CNT_W]),
            .empty_o  (empty_s[v]),
            .full_o   (full_s[v]),
            .credit_o (credit_s[v])
        );
    end

    // Sticky overflow error next-state
    always_comb begin
        overflow_d = overflow_q;
        if (bad_vc_s || (|drop_s)) overflow_d = 1'b1;
        else                       overflow_d = overflow_q;
    end

    // Overflow error register, cleared only by reset
    always_ff @(posedge clk) begin
        if (reset) overflow_q <= 1'b0;
        else       overflow_q <= overflow_d;
    end

    assign bus.head_flits   = head_flat_s;
    assign bus.is_new_flit  = ~empty_s;
    assign bus.credit_out   = credit_s;
    assign bus.overflow_err = overflow_q;

`ifdef INPUT_BUF_OCC_EN
    assign bus.buf_occupancy = count_flat_s;
    assign bus.buf_full      = full_s;
`else
    logic unused_count_s;
    assign unused_count_s = ^count_flat_s;
`endif

endmodule

// File: tb/tb_input_vc_buffer.sv
module tb_input_vc_buffer;
    import input_vc_buffer_pkg::*;

    localparam int VN = 4;
    localparam int VW = 2;
    localparam int BD = 4;
    localparam int FW = FLIT_W_DEF;
    localparam int CW = $clog2(BD) + 1;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    input_vc_buffer_if #(.VC_NUM(VN), .VC_ID_W(VW), .BUF_DEPTH(BD), .FLIT_W(FW)) bus ();

    input_vc_buffer #(.VC_NUM(VN), .VC_ID_W(VW), .BUF_DEPTH(BD), .FLIT_W(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: one queue of flits per VC
    logic [FW-1:0] mq [VN][$];
    logic [VN-1:0] m_credit = '0;
    logic          m_ovf = 1'b0;

    typedef struct {
        logic          rst;
        logic          vld;
        logic [VW-1:0] vc;
        logic [FW-1:0] data;
        logic [VN-1:0] pop;
        logic [VN-1:0] e_new;
        logic [VN-1:0] e_cr;
        logic          e_ovf;
        int            hvc;
        logic [FW-1:0] e_head;
    } vec_t;
    vec_t tbl [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [VW-1:0] vc,
                                input logic [FW-1:0] d, input logic [VN-1:0] p);
        int idx;
        idx = int'(vc);
        if (r) begin
            for (int k = 0; k < VN; k++) mq[k].delete();
            m_credit = '0;
            m_ovf    = 1'b0;
        end else begin
            for (int k = 0; k < VN; k++) begin
                if (p[k] && mq[k].size() > 0) begin
                    m_credit[k] = 1'b1;
                    void'(mq[k].pop_front());
                end else begin
                    m_credit[k] = 1'b0;
                end
            end
            if (v) begin
                if (idx >= VN)                 m_ovf = 1'b1;
                else if (mq[idx].size() < BD)  mq[idx].push_back(d);
                else                           m_ovf = 1'b1;
            end
        end
    endtask

    task automatic model_check();
        logic [VN*FW-1:0] eh;
        logic [VN-1:0]    en;
`ifdef INPUT_BUF_OCC_EN
        logic [VN*CW-1:0] eo;
        logic [VN-1:0]    ef;
        eo = '0;
        ef = '0;
        for (int k = 0; k < VN; k++) begin
            eo[k*CW +: CW] = CW'(mq[k].size());
            ef[k] = (mq[k].size() == BD);
        end
        chk("model.buf_occupancy", 64'(bus.buf_occupancy), 64'(eo));
        chk("model.buf_full", 64'(bus.buf_full), 64'(ef));
`endif
        eh = '0;
        en = '0;
        for (int k = 0; k < VN; k++) begin
            if (mq[k].size() > 0) begin
                en[k] = 1'b1;
                eh[k*FW +: FW] = mq[k][0];
            end
        end
        chk("model.is_new_flit", 64'(bus.is_new_flit), 64'(en));
        chk("model.head_flits", 64'(bus.head_flits), 64'(eh));
        chk("model.credit_out", 64'(bus.credit_out), 64'(m_credit));
        chk("model.overflow_err", 64'(bus.overflow_err), 64'(m_ovf));
    endtask

    // Drive one cycle of inputs, let the edge happen, then compare to the model
    task automatic step(input logic r, input logic v, input logic [VW-1:0] vc,
                        input logic [FW-1:0] d, input logic [VN-1:0] p);
        reset          = r;
        bus.flit_valid = v;
        bus.flit_vc    = vc;
        bus.flit_in    = d;
        bus.pop        = p;
        @(posedge clk);
        #1;
        model_update(r, v, vc, d, p);
        model_check();
    endtask

    task automatic add(input logic r, input logic v, input logic [VW-1:0] vc, input logic [FW-1:0] d,
                       input logic [VN-1:0] p, input logic [VN-1:0] en, input logic [VN-1:0] cr,
                       input logic ov, input int hvc, input logic [FW-1:0] hd);
        vec_t e;
        e.rst = r; e.vld = v; e.vc = vc; e.data = d; e.pop = p;
        e.e_new = en; e.e_cr = cr; e.e_ovf = ov; e.hvc = hvc; e.e_head = hd;
        tbl.push_back(e);
    endtask

    initial begin
        int credits;
        logic [FW-1:0] exp_h;

        reset = 1'b1;
        bus.flit_valid = 1'b0;
        bus.flit_vc    = '0;
        bus.flit_in    = '0;
        bus.pop        = '0;

        //   rst   vld   vc    data   pop      is_new   credit  ovf  hvc head
        add(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 8'h00);
        // single flit to VC 2
        add(1'b0, 1'b1, 2'd2, 8'hA5, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2, 8'hA5);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0100, 4'b0000, 1'b0, 2, 8'hA5);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0100, 4'b0000, 4'b0100, 1'b0, 2, 8'h00);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 2, 8'h00);
        // fill VC 0, fifth write overflows, drain in order
        add(1'b0, 1'b1, 2'd0, 8'h11, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h11);
        add(1'b0, 1'b1, 2'd0, 8'h12, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h11);
        add(1'b0, 1'b1, 2'd0, 8'h13, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h11);
        add(1'b0, 1'b1, 2'd0, 8'h14, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h11);
        add(1'b0, 1'b1, 2'd0, 8'h15, 4'b0000, 4'b0001, 4'b0000, 1'b1, 0, 8'h11);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0001, 1'b1, 0, 8'h12);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0001, 1'b1, 0, 8'h13);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0001, 4'b0001, 1'b1, 0, 8'h14);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 4'b0001, 1'b1, 0, 8'h00);
        // pop on empty VC: no credit
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 1'b1, 0, 8'h00);
        add(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 8'h00);
        // VC 1 full, simultaneous write and pop
        add(1'b0, 1'b1, 2'd1, 8'h21, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1, 8'h21);
        add(1'b0, 1'b1, 2'd1, 8'h22, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1, 8'h21);
        add(1'b0, 1'b1, 2'd1, 8'h23, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1, 8'h21);
        add(1'b0, 1'b1, 2'd1, 8'h24, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1, 8'h21);
        add(1'b0, 1'b1, 2'd1, 8'h25, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1, 8'h22);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1, 8'h23);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1, 8'h24);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 4'b0010, 4'b0010, 1'b0, 1, 8'h25);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0010, 4'b0000, 4'b0010, 1'b0, 1, 8'h00);
        // pop all VCs with only VC 3 occupied
        add(1'b0, 1'b1, 2'd3, 8'h31, 4'b0000, 4'b1000, 4'b0000, 1'b0, 3, 8'h31);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b1111, 4'b0000, 4'b1000, 1'b0, 3, 8'h00);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 3, 8'h00);
        // reset while VC 0 holds 3 flits and is popped
        add(1'b0, 1'b1, 2'd0, 8'h41, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h41);
        add(1'b0, 1'b1, 2'd0, 8'h42, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h41);
        add(1'b0, 1'b1, 2'd0, 8'h43, 4'b0000, 4'b0001, 4'b0000, 1'b0, 0, 8'h41);
        add(1'b1, 1'b0, 2'd0, 8'h00, 4'b0001, 4'b0000, 4'b0000, 1'b0, 0, 8'h00);
        add(1'b0, 1'b0, 2'd0, 8'h00, 4'b0000, 4'b0000, 4'b0000, 1'b0, 0, 8'h00);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].vld, tbl[i].vc, tbl[i].data, tbl[i].pop);
            chk($sformatf("row%0d.is_new_flit", i), 64'(bus.is_new_flit), 64'(tbl[i].e_new));
            chk($sformatf("row%0d.credit_out", i), 64'(bus.credit_out), 64'(tbl[i].e_cr));
            chk($sformatf("row%0d.overflow_err", i), 64'(bus.overflow_err), 64'(tbl[i].e_ovf));
            chk($sformatf("row%0d.head_vc%0d", i, tbl[i].hvc),
                64'(bus.head_flits[tbl[i].hvc*FW +: FW]), 64'(tbl[i].e_head));
        end

        // Ten flits through VC 1 at one pop per cycle: pointers wrap twice
        step(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        step(1'b0, 1'b1, 2'd1, 8'h50, 4'b0000);
        credits = 0;
        for (int i = 1; i <= 10; i++) begin
            exp_h = FW'(32'h50 + i - 1);
            chk($sformatf("wrap.head%0d", i), 64'(bus.head_flits[FW +: FW]), 64'(exp_h));
            step(1'b0, (i < 10), 2'd1, FW'(32'h50 + i), 4'b0010);
            if (bus.credit_out[1]) credits++;
        end
        chk("wrap.credits", 64'(credits), 64'd10);
        chk("wrap.empty", 64'(bus.is_new_flit), 64'd0);
        chk("wrap.no_overflow", 64'(bus.overflow_err), 64'd0);

        // Randomized traffic against the queue model
        step(1'b1, 1'b0, 2'd0, 8'h00, 4'b0000);
        for (int c = 0; c < 3000; c++) begin
            logic [VN-1:0] p;
            for (int k = 0; k < VN; k++) p[k] = ($urandom_range(99) < 35);
            step(($urandom_range(127) == 0), ($urandom_range(99) < 70),
                 VW'($urandom_range(VN - 1)), FW'($urandom), p);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
